apb_initiator: RTL

APB_INITIATOR -- requirements
Module: apb_initiator

---
 rtl/config_pkg.sv | 5 +
 rtl/apb_initiator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/config_pkg.sv
// Shared configuration for the APB initiator.
// XLEN selects the data path width (32 or 64).
package config_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready command into one APB transfer
// and returns the result on a valid/ready response channel.
module apb_initiator
    import config_pkg::*;
#(
    parameter int ADDRW   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               CmdValid,
    output logic               CmdReady,
    input  logic               CmdWrite,
    input  logic [ADDRW-1:0]   CmdAddr,
    input  logic [XLEN-1:0]    CmdWData,
    input  logic [XLEN/8-1:0]  CmdStrb,
    output logic               RspValid,
    input  logic               RspReady,
    output logic [XLEN-1:0]    RspRData,
    output logic               RspErr,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDRW-1:0]   PADDR,
    output logic [XLEN-1:0]    PWDATA,
    output logic [XLEN/8-1:0]  PSTRB,
    input  logic [XLEN-1:0]    PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDRW-1:0]  paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [XLEN-1:0]   pwdata_q, pwdata_d;
    logic [XLEN/8-1:0] pstrb_q, pstrb_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wcnt_d   = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    paddr_d  = CmdAddr;
                    pwrite_d = CmdWrite;
                    pwdata_d = CmdWData;
                    pstrb_d  = CmdWrite ? CmdStrb : '0;
                    wcnt_d   = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave wins over a timeout reached in the same cycle.
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (wcnt_q == TMAX)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RESP: begin
                if (RspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign CmdReady = (state_q == IDLE) & ~PRESET;
    assign PSEL     = (state_q == SETUP) | (state_q == ACCESS);
    assign PENABLE  = (state_q == ACCESS);
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PSTRB    = pstrb_q;
    assign RspValid = (state_q == RESP);
    assign RspRData = rdata_q;
    assign RspErr   = err_q;

endmodule
